// File: rtl/noc_pkg.sv
// Shared NoC widths, the route type and the cluster-match helper.
// Combinational definitions only; no state.
package noc_pkg;

    localparam int DefAddressWidth = 5;
    localparam int DefDataWidth    = 32;
    localparam int DefTotalWidth   = DefAddressWidth + DefDataWidth;

    typedef enum logic {
        ROUTE_LOCAL = 1'b0,
        ROUTE_UP    = 1'b1
    } route_e;

    // Local when every bit above the in-cluster PE select matches our own address.
    function automatic route_e cluster_route(
        input logic [31:0] dest,
        input logic [31:0] own,
        input int          addr_w,
        input int          local_w
    );
        logic [31:0] mask;
        mask = (32'd1 << addr_w) - 32'd1;
        mask = mask & ~((32'd1 << local_w) - 32'd1);
        return (((dest ^ own) & mask) == 32'd0) ? ROUTE_LOCAL : ROUTE_UP;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is the registered entry at the read pointer.
// Head valid one edge after push; push ignored when full, pop ignored when empty.
module noc_sync_fifo #(
    parameter int Width = 37,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[PtrW-1], rd_ptr[PtrW-2:0]});
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[AddrW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AddrW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/noc_ingress_port.sv
// PE ingress: buffers packets, steers the head in order to the local switch or uplink.
// One-edge latency, HOL blocking on the head; statistics counters only with NOC_INGRESS_STATS_EN.
module noc_ingress_port
    import noc_pkg::*;
#(
    parameter int Address      = 0,
    parameter int AddressWidth = DefAddressWidth,
    parameter int DataWidth    = DefDataWidth,
    parameter int TotalWidth   = AddressWidth + DataWidth,
    parameter int LocalWidth   = 2,
    parameter int FifoDepth    = 4,
    parameter int CountWidth   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TotalWidth-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic [TotalWidth-1:0] o_local_data,
    output logic                  o_local_valid,
    input  logic                  i_local_ready,
    output logic [TotalWidth-1:0] o_up_data,
    output logic                  o_up_valid,
    input  logic                  i_up_ready,
    output logic [CountWidth-1:0] o_pkt_in_count,
    output logic [CountWidth-1:0] o_pkt_local_count,
    output logic [CountWidth-1:0] o_pkt_up_count
);

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [TotalWidth-1:0]   head;
    logic [AddressWidth-1:0] dest;
    route_e                  route;
    logic                    is_local;

    assign o_data_ready = rst & ~full;
    assign push         = i_data_valid & o_data_ready;

    noc_sync_fifo #(
        .Width (TotalWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (i_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign dest     = head[DataWidth +: AddressWidth];
    assign route    = cluster_route(32'(dest), 32'(Address), AddressWidth, LocalWidth);
    assign is_local = (route == ROUTE_LOCAL);

    assign o_local_valid = ~empty & is_local;
    assign o_up_valid    = ~empty & ~is_local;
    assign o_local_data  = head;
    assign o_up_data     = head;

    assign pop = (o_local_valid & i_local_ready) | (o_up_valid & i_up_ready);

`ifdef NOC_INGRESS_STATS_EN
    logic [CountWidth-1:0] in_cnt;
    logic [CountWidth-1:0] local_cnt;
    logic [CountWidth-1:0] up_cnt;

    // Saturating: a counter pinned at all-ones stays there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt    <= '0;
            local_cnt <= '0;
            up_cnt    <= '0;
        end else begin
            if (push && !(&in_cnt))
                in_cnt <= in_cnt + 1'b1;
            if (o_local_valid && i_local_ready && !(&local_cnt))
                local_cnt <= local_cnt + 1'b1;
            if (o_up_valid && i_up_ready && !(&up_cnt))
                up_cnt <= up_cnt + 1'b1;
        end
    end

    assign o_pkt_in_count    = in_cnt;
    assign o_pkt_local_count = local_cnt;
    assign o_pkt_up_count    = up_cnt;
`else
    assign o_pkt_in_count    = '0;
    assign o_pkt_local_count = '0;
    assign o_pkt_up_count    = '0;
`endif

endmodule

// File: tb/tb_noc_ingress_port.sv
// Scoreboard bench for noc_ingress_port: Address=12, 5-bit address, 2 local bits, depth 4.
module tb_noc_ingress_port;

    localparam int TW = 37;

    logic          clk;
    logic          rst;
    logic [TW-1:0] i_data;
    logic          i_data_valid;
    logic          o_data_ready;
    logic [TW-1:0] o_local_data;
    logic          o_local_valid;
    logic          i_local_ready;
    logic [TW-1:0] o_up_data;
    logic          o_up_valid;
    logic          i_up_ready;
    logic [15:0]   o_pkt_in_count;
    logic [15:0]   o_pkt_local_count;
    logic [15:0]   o_pkt_up_count;

    noc_ingress_port #(
        .Address      (12),
        .AddressWidth (5),
        .DataWidth    (32),
        .TotalWidth   (37),
        .LocalWidth   (2),
        .FifoDepth    (4),
        .CountWidth   (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_data            (i_data),
        .i_data_valid      (i_data_valid),
        .o_data_ready      (o_data_ready),
        .o_local_data      (o_local_data),
        .o_local_valid     (o_local_valid),
        .i_local_ready     (i_local_ready),
        .o_up_data         (o_up_data),
        .o_up_valid        (o_up_valid),
        .i_up_ready        (i_up_ready),
        .o_pkt_in_count    (o_pkt_in_count),
        .o_pkt_local_count (o_pkt_local_count),
        .o_pkt_up_count    (o_pkt_up_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] data;
        logic          up;
    } exp_t;

    exp_t          sb[$];
    exp_t          exp_head;
    int            checks = 0;
    int            errors = 0;
    logic          held   = 1'b0;
    logic          held_up;
    logic [TW-1:0] held_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    // Reference routing: local iff dest[4:2] equals 12>>2.
    function automatic exp_t make_exp(input logic [TW-1:0] d);
        exp_t e;
        e.data = d;
        e.up   = (d[36:34] != 3'd3);
        return e;
    endfunction

    // Inputs change only at posedge+1, so values seen here are the ones taken at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else begin
            chk("mutex", {63'd0, o_local_valid & o_up_valid}, 64'd0);
            if (held) begin
                chk("hold_valid", {63'd0, held_up ? o_up_valid : o_local_valid}, 64'd1);
                chk("hold_data", {27'd0, held_up ? o_up_data : o_local_data}, {27'd0, held_data});
            end
            if ((o_local_valid && i_local_ready) || (o_up_valid && i_up_ready)) begin
                if (sb.size() == 0) begin
                    chk("spurious_pop", 64'd1, 64'd0);
                end else begin
                    exp_head = sb.pop_front();
                    chk("pop_data", {27'd0, o_local_valid ? o_local_data : o_up_data},
                        {27'd0, exp_head.data});
                    chk("pop_route", {63'd0, o_up_valid}, {63'd0, exp_head.up});
                end
            end
            held      = (o_local_valid && !i_local_ready) || (o_up_valid && !i_up_ready);
            held_up   = o_up_valid;
            held_data = o_up_valid ? o_up_data : o_local_data;
            if (i_data_valid && o_data_ready) sb.push_back(make_exp(i_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] d, input logic [31:0] p);
        int n = 0;
        i_data       = {d, p};
        i_data_valid = 1'b1;
        @(negedge clk);
        while (!o_data_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 64'd0, 64'd1);
        tick();
        i_data_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || o_local_valid || o_up_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst           = 1'b0;
        i_data        = '0;
        i_data_valid  = 1'b0;
        i_local_ready = 1'b1;
        i_up_ready    = 1'b1;
        #12;
        chk("rst_ready", {63'd0, o_data_ready}, 64'd0);
        chk("rst_lvalid", {63'd0, o_local_valid}, 64'd0);
        chk("rst_uvalid", {63'd0, o_up_valid}, 64'd0);
        chk("rst_in_cnt", {48'd0, o_pkt_in_count}, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Single local packet.
        send(5'd13, 32'h64);
        @(negedge clk);
        chk("t1_lvalid", {63'd0, o_local_valid}, 64'd1);
        chk("t1_ldata", {27'd0, o_local_data}, {27'd0, 5'd13, 32'h64});
        chk("t1_uvalid", {63'd0, o_up_valid}, 64'd0);
        @(negedge clk);
        chk("t1_gone", {63'd0, o_local_valid}, 64'd0);

        // Single uplink packet.
        tick();
        send(5'd3, 32'h65);
        @(negedge clk);
        chk("t2_uvalid", {63'd0, o_up_valid}, 64'd1);
        chk("t2_udata", {27'd0, o_up_data}, {27'd0, 5'd3, 32'h65});
        chk("t2_lvalid", {63'd0, o_local_valid}, 64'd0);
        drain();

        // Fill to full with local stalled, then release.
        tick();
        i_local_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(5'd14, 32'h80 + 32'(i));
        @(negedge clk);
        chk("t3_full", {63'd0, o_data_ready}, 64'd0);
        fork
            send(5'd14, 32'h84);
            begin
                repeat (3) @(negedge clk);
                chk("t3_held_off", {63'd0, o_data_ready}, 64'd0);
                chk("t3_sb_four", 64'(sb.size()), 64'd4);
                tick();
                i_local_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("t3_consec", {63'd0, o_local_valid}, 64'd1);
                end
            end
        join
        drain();

        // Head-of-line blocking on the uplink.
        tick();
        i_up_ready = 1'b0;
        send(5'd0, 32'h100);
        send(5'd12, 32'h101);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hol_local", {63'd0, o_local_valid}, 64'd0);
            chk("t4_hol_up", {63'd0, o_up_valid}, 64'd1);
        end
        tick();
        i_up_ready = 1'b1;
        @(negedge clk);
        chk("t4_up_pop", {63'd0, o_up_valid}, 64'd1);
        @(negedge clk);
        chk("t4_local_next", {63'd0, o_local_valid}, 64'd1);
        chk("t4_local_data", {27'd0, o_local_data}, {27'd0, 5'd12, 32'h101});
        drain();

        // Asynchronous reset with two packets buffered.
        tick();
        i_local_ready = 1'b0;
        i_up_ready    = 1'b0;
        send(5'd14, 32'h200);
        send(5'd3, 32'h201);
        @(negedge clk);
        chk("t5_pre_valid", {63'd0, o_local_valid}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_lvalid", {63'd0, o_local_valid}, 64'd0);
        chk("t5_rst_uvalid", {63'd0, o_up_valid}, 64'd0);
        chk("t5_rst_ready", {63'd0, o_data_ready}, 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        i_local_ready = 1'b1;
        i_up_ready    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_valid", {62'd0, o_local_valid, o_up_valid}, 64'd0);
        end
        chk("t5_ready", {63'd0, o_data_ready}, 64'd1);
        chk("t5_in_cnt", {48'd0, o_pkt_in_count}, 64'd0);
        chk("t5_local_cnt", {48'd0, o_pkt_local_count}, 64'd0);
        chk("t5_up_cnt", {48'd0, o_pkt_up_count}, 64'd0);

        // Statistics over a mixed burst.
        tick();
        for (int i = 0; i < 10; i++) send((i < 6) ? 5'd15 : 5'd7, 32'h300 + 32'(i));
        drain();
        repeat (2) @(negedge clk);
`ifdef NOC_INGRESS_STATS_EN
        chk("stats_in", {48'd0, o_pkt_in_count}, 64'd10);
        chk("stats_local", {48'd0, o_pkt_local_count}, 64'd6);
        chk("stats_up", {48'd0, o_pkt_up_count}, 64'd4);
`else
        chk("stats_in", {48'd0, o_pkt_in_count}, 64'd0);
        chk("stats_local", {48'd0, o_pkt_local_count}, 64'd0);
        chk("stats_up", {48'd0, o_pkt_up_count}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
